// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for the RV32I core. Each instruction walks through
// FETCH, DECODE, EXEC, MEM and WB so that a single ALU and a single shared
// instruction/data memory port serve the whole instruction. The combinational
// decoder beside this block still produces the per-opcode datapath selects;
// this block only adds the state-dependent enables.
//
// Parameters:
//   MEM_TIMEOUT  maximum consecutive memory wait cycles before trapping
//                (0 disables the timeout)
//   TO_W         wait counter width, 2**TO_W - 1 >= MEM_TIMEOUT
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset
//   i_op[6:0]      opcode field of the instruction register (valid from DECODE)
//   i_mem_ready    memory ready; transfer completes when req and ready are high
//   o_mem_req      memory request
//   o_mem_we       memory write (meaningful only with o_mem_req)
//   o_addr_sel     memory address source: 0 = PC, 1 = ALU result
//   o_ir_en        load the instruction register from memory read data
//   o_pc_en        PC update strobe, one pulse per retired instruction
//   o_rd_wren      register-file write enable
//   o_state[2:0]   current state, for debug
//   o_trap         sticky trap flag
//
// Optional feature, macro MULTICYCLE_PERF_CNT_EN:
//   o_cycle_cnt[31:0]    cycles spent outside reset and outside TRAP
//   o_instret_cnt[31:0]  retired instructions (cycles with o_pc_en high)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_op,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_addr_sel,
  output logic        o_ir_en,
  output logic        o_pc_en,
  output logic        o_rd_wren,
  output logic [2:0]  o_state,
  output logic        o_trap
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE    = 4'd0,
    C_LOAD    = 4'd1,
    C_OPIMM   = 4'd2,
    C_AUIPC   = 4'd3,
    C_STORE   = 4'd4,
    C_REG     = 4'd5,
    C_LUI     = 4'd6,
    C_BRANCH  = 4'd7,
    C_JALR    = 4'd8,
    C_JAL     = 4'd9,
    C_ILLEGAL = 4'd10
  } cls_t;

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] CNT_MAX     = '1;

  state_t          state, next_state;
  cls_t            cls, cls_next, dec_cls;
  logic [TO_W-1:0] wait_cnt, wait_cnt_next;
  logic            timed_out;

  logic mem_req, mem_we, addr_sel, ir_en, pc_en, rd_wren, trap;

  // Instruction class from the full 7-bit opcode; every listed opcode ends
  // in 2'b11, so any other low-bit pattern falls into the illegal class.
  always_comb begin
    dec_cls = C_ILLEGAL;
    case (i_op)
      7'b0000011: dec_cls = C_LOAD;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0010111: dec_cls = C_AUIPC;
      7'b0100011: dec_cls = C_STORE;
      7'b0110011: dec_cls = C_REG;
      7'b0110111: dec_cls = C_LUI;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1100111: dec_cls = C_JALR;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_cls = C_ILLEGAL;
    endcase
  end

  // A ready in the cycle the limit is reached still wins, so the trap only
  // fires when ready is low.
  assign timed_out = TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL) && !i_mem_ready;

  // Next-state and strobe logic.
  always_comb begin
    next_state = state;
    cls_next   = cls;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    rd_wren    = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = i_mem_ready;
        if (i_mem_ready)    next_state = S_DECODE;
        else if (timed_out) next_state = S_TRAP;
      end
      S_DECODE: begin
        cls_next   = dec_cls;
        next_state = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (cls == C_LOAD || cls == C_STORE) begin
          next_state = S_MEM;
        end else if (cls == C_BRANCH) begin
          // Taken/not-taken is resolved by the datapath's pc_sel.
          pc_en      = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == C_STORE);
        if (i_mem_ready) begin
          if (cls == C_STORE) begin
            pc_en      = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (timed_out) begin
          next_state = S_TRAP;
        end
      end
      S_WB: begin
        rd_wren    = 1'b1;
        pc_en      = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        next_state = S_TRAP;
      end
    endcase
  end

  // Wait counter: restarts for every new request and after each completed
  // transfer, and saturates instead of wrapping.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (mem_req && i_mem_ready)
      wait_cnt_next = '0;
    else if ((next_state != state) && (next_state == S_FETCH || next_state == S_MEM))
      wait_cnt_next = '0;
    else if (mem_req && !i_mem_ready && wait_cnt != CNT_MAX)
      wait_cnt_next = wait_cnt + TO_W'(1);
  end

  // State, class and wait counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_FETCH;
      cls      <= C_NONE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      cls      <= cls_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Outputs are forced low for the whole reset; FETCH would otherwise
  // present a request while reset is still asserted.
  assign o_mem_req  = mem_req  & ~i_reset;
  assign o_mem_we   = mem_we   & ~i_reset;
  assign o_addr_sel = addr_sel & ~i_reset;
  assign o_ir_en    = ir_en    & ~i_reset;
  assign o_pc_en    = pc_en    & ~i_reset;
  assign o_rd_wren  = rd_wren  & ~i_reset;
  assign o_trap     = trap     & ~i_reset;
  assign o_state    = i_reset ? 3'd0 : state;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt   <= cycle_cnt + 32'd1;
      if (pc_en)           instret_cnt <= instret_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt   = cycle_cnt;
  assign o_instret_cnt = instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. Each issued instruction pushes its
// expected observable profile (cycle count, cycles per state, strobe counts,
// retire or trap) into a queue; a monitor pops and compares whenever the DUT
// retires (o_pc_en) or traps (o_trap). A memory responder supplies ready with
// per-request wait counts and presents the opcode once each fetch completes.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  logic        i_clk;
  logic        i_reset;
  logic [6:0]  i_op;
  logic        i_mem_ready;
  logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_en, o_pc_en, o_rd_wren, o_trap;
  logic [2:0]  o_state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_op        (i_op),
    .i_mem_ready (i_mem_ready),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_addr_sel  (o_addr_sel),
    .o_ir_en     (o_ir_en),
    .o_pc_en     (o_pc_en),
    .o_rd_wren   (o_rd_wren),
    .o_state     (o_state),
    .o_trap      (o_trap)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instret_cnt (o_instret_cnt)
`endif
  );

  typedef struct {
    bit          is_trap;
    int          cycles;
    logic [39:0] st_sig;
    int          wren;
    int          we;
    int          req;
    int          asel;
    int          iren;
  } exp_t;

  exp_t       exp_q[$];
  int         wait_q[$];
  logic [6:0] op_q[$];

  logic [6:0] legal_ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

  int n_cmp = 0;
  int n_bad = 0;

  int acc_st [8];
  int acc_cyc, acc_wren, acc_we, acc_req, acc_asel, acc_iren, acc_inv;
  int ep_cyc, ep_ret;
  bit trapped;

  // Clock generation.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Global watchdog so the run always ends.
  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outVec();
    return 64'({o_mem_req, o_mem_we, o_addr_sel, o_ir_en, o_pc_en, o_rd_wren, o_trap, o_state});
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    bit r;
    r = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) r = 1'b1;
    return r;
  endfunction

  // Reference profile of one instruction from the sequencing rules:
  // FETCH lasts fw+1 cycles, DECODE and EXEC one each, MEM mw+1 for loads and
  // stores, WB one for anything that writes a register; a wait run longer than
  // TIMEOUT traps after TIMEOUT+1 request cycles.
  function automatic exp_t refModel(input logic [6:0] op, input int fw, input int mw);
    exp_t e;
    int   st [5];
    bit   is_ld, is_st, is_br, ldst;
    int   base;
    e = '{default: 0};
    foreach (st[k]) st[k] = 0;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    is_br = (op == OP_BRANCH);
    ldst  = is_ld || is_st;
    base  = is_ld ? 5 : (is_br ? 3 : 4);
    if (fw > TIMEOUT) begin
      e.is_trap = 1; st[0] = TIMEOUT + 1; e.req = TIMEOUT + 1; e.cycles = TIMEOUT + 1;
    end else if (!isLegal(op)) begin
      e.is_trap = 1; st[0] = fw + 1; st[1] = 1; e.req = fw + 1; e.iren = 1; e.cycles = fw + 2;
    end else if (ldst && mw > TIMEOUT) begin
      e.is_trap = 1; st[0] = fw + 1; st[1] = 1; st[2] = 1; st[3] = TIMEOUT + 1;
      e.req = fw + 1 + TIMEOUT + 1; e.asel = TIMEOUT + 1; e.we = is_st ? TIMEOUT + 1 : 0;
      e.iren = 1; e.cycles = fw + 3 + TIMEOUT + 1;
    end else begin
      st[0] = fw + 1; st[1] = 1; st[2] = 1;
      st[3] = ldst ? mw + 1 : 0;
      st[4] = (is_st || is_br) ? 0 : 1;
      e.req    = fw + 1 + (ldst ? mw + 1 : 0);
      e.asel   = ldst ? mw + 1 : 0;
      e.wren   = st[4];
      e.we     = is_st ? mw + 1 : 0;
      e.iren   = 1;
      e.cycles = base + fw + (ldst ? mw : 0);
    end
    e.st_sig = {8'(st[4]), 8'(st[3]), 8'(st[2]), 8'(st[1]), 8'(st[0])};
    return e;
  endfunction

  function automatic bit pushInstr(input logic [6:0] op, input int fw, input int mw);
    exp_t e;
    e = refModel(op, fw, mw);
    op_q.push_back(op);
    wait_q.push_back(fw);
    if (op == OP_LOAD || op == OP_STORE) wait_q.push_back(mw);
    exp_q.push_back(e);
    return e.is_trap;
  endfunction

  function automatic logic [6:0] randOp();
    logic [6:0] op;
    if ($urandom_range(0, 9) == 0) begin
      op = 7'($urandom_range(0, 127));
      while (isLegal(op)) op = 7'($urandom_range(0, 127));
    end else begin
      op = legal_ops[$urandom_range(0, 8)];
    end
    return op;
  endfunction

  function automatic int randWait();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return 16;
    if (r < 3)  return 15;
    return r % 4;
  endfunction

  function automatic void clearAcc();
    foreach (acc_st[k]) acc_st[k] = 0;
    acc_cyc = 0; acc_wren = 0; acc_we = 0; acc_req = 0; acc_asel = 0; acc_iren = 0; acc_inv = 0;
  endfunction

  // Memory responder: consumes one wait count per request, holds ready low
  // for that many request cycles, then completes the transfer. The opcode is
  // presented at the same time the fetch completes. Outside requests ready is
  // random, which the sequencer must ignore.
  initial begin
    bit need_load;
    int wait_left;
    i_mem_ready = 1'b0;
    i_op        = 7'h00;
    need_load   = 1'b1;
    wait_left   = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        need_load   = 1'b1;
        i_mem_ready = 1'b0;
      end else if (o_mem_req) begin
        if (need_load) begin
          wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          need_load = 1'b0;
        end
        if (wait_left > 0) begin
          i_mem_ready = 1'b0;
          wait_left--;
        end else begin
          i_mem_ready = 1'b1;
          need_load   = 1'b1;
          if (!o_addr_sel) i_op = (op_q.size() > 0) ? op_q.pop_front() : OP_OPIMM;
        end
      end else begin
        i_mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: accumulates the observed per-instruction profile and compares it
  // with the scoreboard entry on every retire or trap.
  initial begin
    exp_t        e;
    logic [39:0] sig;
    clearAcc();
    trapped = 1'b0;
    ep_cyc  = 0;
    ep_ret  = 0;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_reset) begin
        clearAcc();
        trapped = 1'b0;
        ep_cyc  = 0;
        ep_ret  = 0;
      end else if (trapped) begin
        checkOutput("trap_hold", outVec(), 64'h0D);
      end else if (o_trap) begin
        trapped = 1'b1;
        sig = {8'(acc_st[4]), 8'(acc_st[3]), 8'(acc_st[2]), 8'(acc_st[1]), 8'(acc_st[0])};
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL unexpected_trap: got trap, expected no event");
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind_trap", 64'(o_trap), 64'(e.is_trap));
          checkOutput("trap_cycles",     64'(acc_cyc),  64'(e.cycles));
          checkOutput("trap_state_prof", 64'(sig),      64'(e.st_sig));
          checkOutput("trap_req_cycles", 64'(acc_req),  64'(e.req));
          checkOutput("trap_we_cycles",  64'(acc_we),   64'(e.we));
          checkOutput("trap_iren",       64'(acc_iren), 64'(e.iren));
        end
        checkOutput("trap_hold", outVec(), 64'h0D);
      end else begin
        ep_cyc++;
        acc_cyc++;
        acc_st[o_state]++;
        if (o_rd_wren) acc_wren++;
        if (o_mem_we)  acc_we++;
        if (o_mem_req) acc_req++;
        if (o_mem_req && o_addr_sel) acc_asel++;
        if (o_ir_en)   acc_iren++;
        if ((o_rd_wren && o_state != 3'd4) || (o_mem_we && o_state != 3'd3)) acc_inv++;
        if (o_pc_en) begin
          sig = {8'(acc_st[4]), 8'(acc_st[3]), 8'(acc_st[2]), 8'(acc_st[1]), 8'(acc_st[0])};
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_retire: got retire, expected no event");
          end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind_retire", 64'(o_trap),   64'(e.is_trap));
            checkOutput("instr_cycles",      64'(acc_cyc),  64'(e.cycles));
            checkOutput("state_profile",     64'(sig),      64'(e.st_sig));
            checkOutput("rd_wren_cycles",    64'(acc_wren), 64'(e.wren));
            checkOutput("mem_we_cycles",     64'(acc_we),   64'(e.we));
            checkOutput("mem_req_cycles",    64'(acc_req),  64'(e.req));
            checkOutput("addr_sel_cycles",   64'(acc_asel), 64'(e.asel));
            checkOutput("ir_en_cycles",      64'(acc_iren), 64'(e.iren));
            checkOutput("strobe_invariant",  64'(acc_inv),  64'd0);
          end
`ifdef MULTICYCLE_PERF_CNT_EN
          checkOutput("instret_cnt", 64'(o_instret_cnt), 64'(ep_ret));
          checkOutput("cycle_cnt",   64'(o_cycle_cnt),   64'(ep_cyc - 1));
`endif
          ep_ret++;
          clearAcc();
        end
      end
    end
  end

  task automatic doReset();
    @(posedge i_clk);
    #2 i_reset = 1'b1;
    @(negedge i_clk);
    #1 checkOutput("reset_outputs_zero", outVec(), 64'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    checkOutput("reset_perf_zero", {o_cycle_cnt, o_instret_cnt}, 64'd0);
`endif
    exp_q.delete();
    wait_q.delete();
    op_q.delete();
  endtask

  task automatic releaseReset();
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1 checkOutput("post_reset_fetch", 64'({o_mem_req, o_trap, o_state}), 64'b1_0_000);
  endtask

  // Runs the queued program from reset release until the scoreboard drains,
  // holds a trapped DUT for 20 cycles, then resets again.
  task automatic applyStimulus(input bit expect_trap);
    int budget;
    budget = 40;
    foreach (exp_q[k]) budget += exp_q[k].cycles;
    releaseReset();
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge i_clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
    end
    if (expect_trap) repeat (20) @(posedge i_clk);
    doReset();
  endtask

  initial begin
    bit tr;
    int n;
    i_reset = 1'b1;
    #1 checkOutput("initial_reset_zero", outVec(), 64'd0);

    $display("[TB] directed: addi, lw/sw with waits, beq");
    void'(pushInstr(OP_OPIMM, 0, 0));
    applyStimulus(1'b0);
    void'(pushInstr(OP_LOAD, 2, 2));
    void'(pushInstr(OP_STORE, 2, 2));
    applyStimulus(1'b0);
    void'(pushInstr(OP_BRANCH, 0, 0));
    void'(pushInstr(OP_OPIMM, 1, 0));
    applyStimulus(1'b0);

    $display("[TB] directed: illegal opcode and timeouts");
    void'(pushInstr(OP_OPIMM, 0, 0));
    tr = pushInstr(7'h7F, 0, 0);
    applyStimulus(tr);
    tr = pushInstr(OP_OPIMM, 16, 0);
    applyStimulus(tr);
    void'(pushInstr(OP_OPIMM, 15, 0));
    void'(pushInstr(OP_LOAD, 0, 15));
    void'(pushInstr(OP_STORE, 0, 15));
    tr = pushInstr(OP_LOAD, 0, 16);
    applyStimulus(tr);

    $display("[TB] directed: ten addi back to back");
    for (int k = 0; k < 10; k++) void'(pushInstr(OP_OPIMM, 0, 0));
    applyStimulus(1'b0);

    $display("[TB] directed: reset asserted in the middle of a memory request");
    void'(pushInstr(OP_LOAD, 0, 40));
    releaseReset();
    n = 0;
    while (o_state != 3'd3 && n < 20) begin
      @(posedge i_clk);
      #1 n++;
    end
    checkOutput("reach_mem_state", 64'(o_state), 64'd3);
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1 checkOutput("async_reset_mid_mem", outVec(), 64'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    checkOutput("async_reset_perf_zero", {o_cycle_cnt, o_instret_cnt}, 64'd0);
`endif
    exp_q.delete();
    wait_q.delete();
    op_q.delete();

    $display("[TB] random episodes");
    for (int ep = 0; ep < 30; ep++) begin
      n  = $urandom_range(3, 8);
      tr = 1'b0;
      for (int k = 0; k < n && !tr; k++) tr = pushInstr(randOp(), randWait(), randWait());
      applyStimulus(tr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB so that one ALU and one shared instruction/data memory port serve the whole instruction. It sits beside the combinational decoder, which still produces the per-opcode datapath selects. This block adds the state-dependent enables: PC/IR/register-file writes, memory request/handshake and trap.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles on a memory request before trapping; 0 disables the timeout.
- `TO_W`, default 4: width of the wait counter; must satisfy 2^TO_W − 1 ≥ `MEM_TIMEOUT`.

Ports:
- `i_clk`  in  1: clock. One clock; all state changes on the rising edge.
- `i_reset`  in  1: reset. Asynchronous, active-high.
- `i_op`  in  7: opcode field of the instruction register, valid from DECODE onward.
- `i_mem_ready`  in  1: memory ready. A transfer completes on a rising edge where `o_mem_req` and `i_mem_ready` are both high.
- `o_mem_req`  out  1: memory request.
- `o_mem_we`  out  1: memory write, meaningful only with `o_mem_req`.
- `o_addr_sel`  out  1: memory address source; 0 = PC, 1 = ALU result.
- `o_ir_en`  out  1: load the instruction register from memory read data.
- `o_pc_en`  out  1: PC update strobe; the datapath's pc_sel selects the PC source.
- `o_rd_wren`  out  1: register-file write enable (already qualified; the decoder's write enable is not used directly).
- `o_state`  out  3: current state, for debug.
- `o_trap`  out  1: sticky trap flag.

## Operation
State encoding, one register updated on the rising edge:
- FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are illegal and go to TRAP on the next edge.

Instruction classes, decoded from `i_op` (`i_op[1:0]` must be 2'b11):
- load 0000011, opimm 0010011, auipc 0010111, store 0100011, reg 0110011, lui 0110111, branch 1100011, jalr 1100111, jal 1101111.
- Any other `i_op` is illegal.

Per-state behaviour:
- FETCH: `o_mem_req`=1, `o_addr_sel`=0, `o_mem_we`=0, `o_ir_en`=`i_mem_ready`. On ready → DECODE.
- DECODE: registers the class. Illegal → TRAP; otherwise → EXEC.
- EXEC: ALU evaluates.
  - load or store → MEM.
  - branch → FETCH with `o_pc_en`=1 in this cycle; the datapath resolves taken/not-taken through pc_sel.
  - all other classes → WB.
- MEM: `o_mem_req`=1, `o_addr_sel`=1, `o_mem_we` = (class == store). On ready: load → WB; store → FETCH with `o_pc_en`=1 in the ready cycle.
- WB: `o_rd_wren`=1 and `o_pc_en`=1 for one cycle → FETCH.
- TRAP: all strobes 0, `o_trap`=1. Held until reset.

Wait counter (`TO_W` bits):
- Cleared on entry to FETCH or MEM and on every completed transfer.
- Increments each cycle with `o_mem_req`=1 and `i_mem_ready`=0.
- If the counter equals `MEM_TIMEOUT` (nonzero) and `i_mem_ready`=0 → TRAP.
- A ready arriving in the same cycle the count is reached wins: the transfer completes and no trap is taken.
- Saturates; never wraps.

Invariants:
- `o_pc_en` pulses exactly once per retired instruction.
- `o_rd_wren` is never high outside WB.
- `o_mem_we` is never high outside MEM.

## Timing
- Reset: state=FETCH, wait counter=0, class=0, `o_trap`=0. While `i_reset` is high, every output is forced to 0, including `o_mem_req`. The first fetch request appears in the first cycle after deassertion.
- Reset asserted mid-request abandons the transfer immediately, asynchronously.
- Outputs are combinational from state, class and `i_mem_ready`. There are no output registers.
- Cycle counts with zero-wait memory: reg/opimm/lui/auipc/jal/jalr 4, load 5, store 4, branch 3. Each memory wait cycle adds 1.
- `i_mem_ready` outside a request is ignored.
- A request holds its address select and write values stable until accepted.

## Configuration
- Macro `MULTICYCLE_PERF_CNT_EN`.
- Defined: adds output ports `o_cycle_cnt` (32 bits) and `o_instret_cnt` (32 bits), both reset to 0.
  - `o_cycle_cnt` increments every cycle outside reset and outside TRAP.
  - `o_instret_cnt` increments on every cycle with `o_pc_en`=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- addi (0x00500093), ready always high → states 0,1,2,4,0; `o_ir_en` high in cycle 1; `o_rd_wren` and `o_pc_en` high only in cycle 4.
- lw, then sw, with 2 wait cycles on every request → lw 9 cycles with `o_addr_sel`=1 in MEM and `o_rd_wren` in WB; sw 8 cycles with `o_mem_we`=1 only in MEM and no `o_rd_wren`.
- beq → 3 cycles; `o_pc_en` only in EXEC; no `o_rd_wren` or memory access beyond the fetch.
- Illegal opcode 0x7F → TRAP one cycle after DECODE; `o_trap`=1 and all strobes 0 for 20 further cycles; `i_reset` then returns state 0 with `o_trap`=0.
- `MEM_TIMEOUT`=15 with ready held low → TRAP after 15 wait cycles. Separately, ready asserted in the 15th wait cycle → DECODE, no trap.
- With `MULTICYCLE_PERF_CNT_EN`: 10 addi with zero-wait memory → `o_instret_cnt`=10, `o_cycle_cnt`=40. `i_reset` asserted mid-MEM → both counters and all outputs 0 immediately.
